// File: rtl/scpad_bank_req_ctrl.sv
// -----------------------------------------------------------------------------
// scpad_types_pkg / scpad_bank_req_ctrl
//
// Purpose:
//   Per-bank request controller placed directly in front of one sram_bank.
//   Tagged read/write requests are queued in a small in-order FIFO and issued
//   to the bank one at a time as single-cycle ren/wen strobes. The controller
//   waits for the matching done strobe, captures read data and returns a
//   tagged response over a valid/ready channel. A watchdog aborts an operation
//   that never completes and reports it with rsp_err.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_we, req_addr, req_wdata, req_tag
//   rsp_valid/rsp_ready  response handshake; rsp_we, rsp_tag, rsp_data, rsp_err
//   occupancy            number of queued (not yet issued) requests
//   bank_busy            bank cannot accept an operation this cycle
//   bank_ren/bank_raddr  read strobe and row; bank_rdata/bank_rdone returned
//   bank_wen/bank_waddr  write strobe and row; bank_wdata; bank_wdone returned
// -----------------------------------------------------------------------------
package scpad_types_pkg;
  localparam int ROW_IDX_WIDTH = 6;
  localparam int ELEM_BITS     = 32;
endpackage

module scpad_bank_req_ctrl
  import scpad_types_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         n_rst,
  // request channel
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ROW_IDX_WIDTH-1:0]     req_addr,
  input  logic [ELEM_BITS-1:0]         req_wdata,
  input  logic [TAG_W-1:0]             req_tag,
  // response channel
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_we,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [ELEM_BITS-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]  occupancy,
  // sram_bank interface
  input  logic                         bank_busy,
  output logic                         bank_ren,
  output logic [ROW_IDX_WIDTH-1:0]     bank_raddr,
  input  logic [ELEM_BITS-1:0]         bank_rdata,
  input  logic                         bank_rdone,
  output logic                         bank_wen,
  output logic [ROW_IDX_WIDTH-1:0]     bank_waddr,
  output logic [ELEM_BITS-1:0]         bank_wdata,
  input  logic                         bank_wdone
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR, RESP} state_t;

  typedef struct packed {
    logic                     we;
    logic [ROW_IDX_WIDTH-1:0] addr;
    logic [ELEM_BITS-1:0]     wdata;
    logic [TAG_W-1:0]         tag;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_issue;
  req_t w_head;

  assign w_full  = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = req_valid && !w_full;
  assign w_head  = r_fifo[r_rd_ptr];

  // NOTE: the entry storage carries no reset; the pointers and count alone
  // define which entries are valid, so resetting the array buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata, tag: req_tag};
    end
  end

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // FIFO_DEPTH is a power of two, so pointers wrap naturally.
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign req_ready = !w_full;
  assign occupancy = r_count;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_next_state;
  logic [WD_W-1:0] r_wdog;
  logic            w_wdog_hit;
  logic            w_complete;
  logic            w_abort;
  logic            r_rsp_valid;

  // The watchdog reads 1 in the first WAIT cycle, so an abort decided when it
  // reads TIMEOUT-1 puts the error response on the bus TIMEOUT cycles after issue.
  assign w_wdog_hit = (r_wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: defaults are assigned before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !bank_busy && !r_rsp_valid) begin
          w_issue      = 1'b1;
          w_next_state = w_head.we ? WAIT_WR : WAIT_RD;
        end
      end
      WAIT_RD: begin
        // A genuine completion wins over an abort landing in the same cycle.
        if (bank_rdone) begin
          w_complete   = 1'b1;
          w_next_state = RESP;
        end else if (w_wdog_hit) begin
          w_abort      = 1'b1;
          w_next_state = RESP;
        end
      end
      WAIT_WR: begin
        if (bank_wdone) begin
          w_complete   = 1'b1;
          w_next_state = RESP;
        end else if (w_wdog_hit) begin
          w_abort      = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wdog <= '0;
    end else if (w_issue) begin
      r_wdog <= WD_W'(1);
    end else if (r_state == WAIT_RD || r_state == WAIT_WR) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank strobes: combinational from the FIFO head during issue; the address
  // and data buses hold the last issued values in every other cycle.
  // ---------------------------------------------------------------------------
  logic [ROW_IDX_WIDTH-1:0] r_raddr;
  logic [ROW_IDX_WIDTH-1:0] r_waddr;
  logic [ELEM_BITS-1:0]     r_wdata;
  logic                     w_rd_issue;
  logic                     w_wr_issue;

  assign w_rd_issue = w_issue && !w_head.we;
  assign w_wr_issue = w_issue &&  w_head.we;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_raddr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (w_rd_issue) r_raddr <= w_head.addr;
      if (w_wr_issue) begin
        r_waddr <= w_head.addr;
        r_wdata <= w_head.wdata;
      end
    end
  end

  assign bank_ren   = w_rd_issue;
  assign bank_wen   = w_wr_issue;
  assign bank_raddr = w_rd_issue ? w_head.addr  : r_raddr;
  assign bank_waddr = w_wr_issue ? w_head.addr  : r_waddr;
  assign bank_wdata = w_wr_issue ? w_head.wdata : r_wdata;

  // ---------------------------------------------------------------------------
  // Response register. Tag and direction are latched at issue; no new issue
  // can happen while a response is pending, so they stay stable in RESP.
  // ---------------------------------------------------------------------------
  logic                 r_rsp_we;
  logic [TAG_W-1:0]     r_rsp_tag;
  logic [ELEM_BITS-1:0] r_rsp_data;
  logic                 r_rsp_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_rsp_we  <= w_head.we;
        r_rsp_tag <= w_head.tag;
      end
      if (w_complete) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_data  <= (r_state == WAIT_RD) ? bank_rdata : '0;
      end else if (w_abort) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_data  <= '0;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule
